// File: rtl/calc_disp_pkg.sv
// Shared constants for the calculator display stage: segment patterns,
// the blank digit code, calculator status encodings and error-glyph codes.
package calc_disp_pkg;

   localparam logic [3:0] BLANK = 4'hF;

   typedef enum logic [1:0] {
      ST_ERR   = 2'b00,
      ST_BUSY  = 2'b01,
      ST_READY = 2'b10,
      ST_PRINT = 2'b11
   } calc_status_e;

   // Active-low segments {dp,g,f,e,d,c,b,a}
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_E     = 8'h86;
   localparam logic [7:0] SEG_R     = 8'hAF;
   localparam logic [7:0] SEG_O     = 8'hA3;

   // Glyph codes understood by the decoder when err_char is set
   localparam logic [3:0] ERR_E = 4'd0;
   localparam logic [3:0] ERR_R = 4'd1;
   localparam logic [3:0] ERR_O = 4'd2;

   // "Erro" laid out on digits 3..0, upper digits blank
   function automatic logic [3:0] err_code(input logic [2:0] idx);
      case (idx)
         3'd0:    return ERR_O;
         3'd1:    return ERR_R;
         3'd2:    return ERR_R;
         3'd3:    return ERR_E;
         default: return BLANK;
      endcase
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational seven-segment decoder: decimal digits, or the E/r/o glyphs
// when err_char is set. Anything else renders blank.
module seg7_decoder
   import calc_disp_pkg::*;
(
   input  logic [3:0] code,
   input  logic       err_char,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (err_char) begin
         case (code)
            ERR_E:   seg = SEG_E;
            ERR_R:   seg = SEG_R;
            ERR_O:   seg = SEG_O;
            default: seg = SEG_BLANK;
         endcase
      end else begin
         case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/calc_display.sv
// Calculator output stage: shadow-buffers the printed digit stream, commits
// whole frames, and scans them onto eight active-low 7-segment digits.
// Define CALC_DISP_LZB_EN to enable leading-zero blanking.
module calc_display
   import calc_disp_pkg::*;
#(
   parameter int SCAN_DIV = 100000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] status,
   input  logic [3:0] data,
   input  logic [3:0] pos,
   output logic [7:0] an,
   output logic [7:0] seg
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

   logic [PW-1:0] presc;
   logic          tick;
   logic [2:0]    scan_idx;
   logic [3:0]    pos_q;
   logic [3:0]    shadow [8];
   logic [3:0]    active [8];
   logic          err;
   logic [2:0]    wr_idx;
   logic          do_capture;
   logic          do_commit;
   logic [7:0]    show;
   logic [3:0]    code;
   logic [7:0]    seg_d;

   assign tick       = (presc == PRESC_MAX);
   assign wr_idx     = 3'(pos - 4'd1);
   assign do_commit  = (pos_q == 4'd8) && (pos == 4'd0);
   assign do_capture = (pos != pos_q) && (pos >= 4'd1) && (pos <= 4'd8);

   always_ff @(posedge clock) begin
      if (reset) begin
         presc    <= '0;
         scan_idx <= 3'd0;
      end else if (tick) begin
         presc    <= '0;
         scan_idx <= scan_idx + 3'd1;
      end else begin
         presc    <= presc + PW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pos_q <= 4'd0;
         err   <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            shadow[i] <= BLANK;
            active[i] <= BLANK;
         end
      end else begin
         pos_q <= pos;
         if (status == ST_ERR)
            err <= 1'b1;
         // Frame commit empties the shadow so a short next frame shows no stale digits
         if (do_commit) begin
            for (int i = 0; i < 8; i++) begin
               active[i] <= shadow[i];
               shadow[i] <= BLANK;
            end
         end else if (do_capture) begin
            shadow[wr_idx] <= data;
         end
      end
   end

`ifdef CALC_DISP_LZB_EN
   logic lz_seen;
   // A digit renders once any digit at or above it holds 1-9; digit 0 always renders
   always_comb begin
      lz_seen = 1'b0;
      show    = '0;
      for (int i = 7; i >= 0; i--) begin
         if ((active[i] >= 4'd1) && (active[i] <= 4'd9))
            lz_seen = 1'b1;
         show[i] = lz_seen || (i == 0);
      end
   end
`else
   assign show = 8'hFF;
`endif

   always_comb begin
      code = BLANK;
      if (err)
         code = err_code(scan_idx);
      else if (show[scan_idx])
         code = active[scan_idx];
   end

   seg7_decoder u_dec (
      .code     (code),
      .err_char (err),
      .seg      (seg_d)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         an  <= 8'hFF;
         seg <= 8'hFF;
      end else begin
         an  <= ~(8'b1 << scan_idx);
         seg <= seg_d;
      end
   end

endmodule

// File: doc/calc_display.md
# calc_display

Output stage of the calculator. Consumes the `status`/`data`/`pos` digit stream the calculator FSM emits while printing (one decimal digit per cycle, least-significant first, `pos` stepping 1..8 then back to 0). Collects a full 8-digit frame in a shadow buffer, commits it atomically, and time-multiplexes it onto eight active-low seven-segment displays. Also shows a fixed "Erro" pattern once the calculator reports error.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per display digit slot; legal range ≥ 1.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `status` in 2: calculator status; 00 error, 01 busy, 10 ready, 11 printing.
- `data` in 4: digit value from the calculator; 0-9 valid, 10-15 rendered blank.
- `pos` in 4: calculator position counter; values 1..8 address digit `pos-1`.
- `an` out 8: digit enables, active-low, one-hot-low; bit i = digit i (0 = rightmost).
- `seg` out 8: segments `{dp,g,f,e,d,c,b,a}`, active-low; dp always 1.

## Operation
- Capture: register `pos_q` every cycle. When `pos != pos_q` and `pos` in 1..8, write `shadow[pos-1] <= data`. `pos` values 9-15 are ignored.
- Commit: when `pos_q == 8` and `pos == 0`, copy all of `shadow` to `active`, then fill `shadow` with blank code 4'hF. A capture and a commit never coincide.
- Error: when `status == 00` is sampled, set sticky `err`. Only `reset` clears it. While `err` is set, the display shows digits 3..0 = E,r,r,o and digits 7..4 blank; capture and commit continue unaffected.
- Scan: a prescaler counts 0..SCAN_DIV-1. On wrap it issues a tick, and the tick advances `scan_idx` 0→7 with wrap to 0.
- Output: every cycle, register `an <= ~(1 << scan_idx)` and `seg <= encode(selected digit)`.
- Encoding (active-low hex): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, blank FF, E 86, r AF, o A3.
- Arithmetic: prescaler width is `$clog2(SCAN_DIV)`, minimum 1 bit. `scan_idx` is 3 bits and wraps naturally.

## Timing
- Reset values: `an` = FF and `seg` = FF; shadow and active all 4'hF; `pos_q` = 0; `scan_idx` = 0; prescaler = 0; `err` = 0.
- Capture latency: 1 cycle after the `pos` change, the value is in `shadow`.
- Commit latency: `active` updates on the edge that samples `pos == 0`; `seg` reflects it 1 cycle later for the digit currently scanned.
- `err` latency: `seg` shows the error pattern from the 2nd edge after `status == 00` is sampled.
- Scan: each digit is enabled for exactly `SCAN_DIV` cycles; full refresh takes 8×`SCAN_DIV` cycles. With `SCAN_DIV` = 1, the digit advances every cycle.
- Reset mid-frame: a partial frame is discarded and the next commit carries only post-reset captures. Mid-scan reset returns to digit 0 with outputs off for 1 cycle.
- No handshake back to the calculator; the block is a passive listener and never stalls the source.

## Configuration
- `CALC_DISP_LZB_EN` defined: leading-zero blanking on `active`. Digits above the highest digit holding a value 1-9 render blank; digit 0 always renders, so 0 shows as a single "0".
- `CALC_DISP_LZB_EN` undefined: every digit renders its raw value. Stored 0 shows "0"; codes 10-15 show blank.
- The error pattern is unaffected by the macro.

## Structure
- Package `calc_disp_pkg` holds:
  - segment constants for 0-9, blank, E, r, o;
  - `BLANK` = 4'hF;
  - the calculator status encodings (`ST_ERR`, `ST_BUSY`, `ST_READY`, `ST_PRINT`).
- Sub-module `seg7_decoder` is combinational: 4-bit code plus `err_char` select in, 8-bit active-low segments out. Instantiated once, after the digit mux.
- The blanking mask is computed combinationally from `active` in the top module.

## Test plan
- Reset → `an` = FF and `seg` = FF on the first post-reset cycle; after the 2nd edge, `an` = FE and `seg` = FF.
- Frame "00000123" (pos 1..8 with data 3,2,1,0,0,0,0,0, then pos 0), `SCAN_DIV` = 1 → digit0 B0, digit1 A4, digit2 F9. With LZB_EN digits 3-7 show FF; without it they show C0.
- All-zero frame with LZB_EN → digit 0 shows C0; digits 1-7 show FF.
- Partial frame (pos 1..4), then `reset`, then full frame "87654321" → digits 7..0 show 80, F8, 82, 92, 99, B0, A4, F9; there is no residue from the partial frame.
- `status` = 00 for 1 cycle mid-frame → digits 3..0 show 86, AF, AF, A3 and digits 7..4 show FF; the pattern persists through later commits until `reset`.
- `SCAN_DIV` = 4 → `an` walks FE, FD, …, 7F, FE with exactly 4 cycles per step; `data` = 12 in a frame renders FF.
